meas_avg: RTL

Measurement post-processor downstream of `alg_box`. Consumes the per-shot result strobe (`done_measure` / `err_measure` / `data_measure`), discards failed shots, and keeps a sliding-window average of valid echo widths. It optionally scales the widths to millimetres. Results and status are exposed as byte registers on the fx bus, so the host reads them over UART through `commu_top`.

---
 rtl/sg_pkg.sv | 36 +++
 rtl/meas_mm_conv.sv | 63 ++++++
 rtl/meas_avg.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sg_pkg.sv
// sg_pkg: shared definitions for the measurement post-processor.
//   - fx-bus address/data widths
//   - register offsets of meas_avg (ma_reg_e)
//   - packed status word layout (ma_stat_t)
//   - MM_SCALE and the us->mm conversion helper used when MEAS_AVG_MM_EN is defined
package sg_pkg;

  localparam int FX_AW = 22;
  localparam int FX_DW = 8;

  // 11241 / 65536 = 0.17152 mm per microsecond of round-trip echo time
  localparam logic [15:0] MM_SCALE = 16'd11241;

  typedef enum logic [2:0] {
    MA_REG_AVG_L = 3'd0,
    MA_REG_AVG_H = 3'd1,
    MA_REG_RAW_L = 3'd2,
    MA_REG_RAW_H = 3'd3,
    MA_REG_STAT  = 3'd4,
    MA_REG_ERR   = 3'd5,
    MA_REG_CNT   = 3'd6
  } ma_reg_e;

  // Bit 1: an error shot has been seen since the last valid shot.
  // Bit 0: the averaging window holds at least one sample.
  typedef struct packed {
    logic err_seen;
    logic win_vld;
  } ma_stat_t;

  // Full 32-bit product, upper half kept (truncating divide by 65536)
  function automatic logic [15:0] us_to_mm(input logic [15:0] us);
    return 16'((32'(us) * 32'(MM_SCALE)) >> 16);
  endfunction

endpackage

// File: rtl/meas_mm_conv.sv
// meas_mm_conv: stage-1 capture register of meas_avg.
// Optional feature macro: MEAS_AVG_MM_EN (when defined, the captured sample is
// converted from microseconds to millimetres before being registered).
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   shot_vld_i   accepted (non-failed) shot strobe
//   shot_data_i  echo width in microseconds
//   vld_o        registered sample valid (one cycle after shot_vld_i)
//   data_o       registered sample (mm or us depending on MEAS_AVG_MM_EN)
//   raw_o        registered unconverted sample (last_raw)
module meas_mm_conv
  import sg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        shot_vld_i,
  input  logic [15:0] shot_data_i,
  output logic        vld_o,
  output logic [15:0] data_o,
  output logic [15:0] raw_o
);

  logic        vld_q, vld_d;
  logic [15:0] data_q, data_d;
  logic [15:0] raw_q, raw_d;
  logic [15:0] conv;

  // The multiplier sits in front of the register so latency is identical
  // whether or not the conversion is built.
`ifdef MEAS_AVG_MM_EN
  assign conv = us_to_mm(shot_data_i);
`else
  assign conv = shot_data_i;
`endif

  always_comb begin
    vld_d  = shot_vld_i;
    data_d = data_q;
    raw_d  = raw_q;
    if (shot_vld_i) begin
      data_d = conv;
      raw_d  = shot_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      raw_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      raw_q  <= raw_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign raw_o  = raw_q;

endmodule

// File: rtl/meas_avg.sv
// meas_avg: sliding-window average of valid echo widths from alg_box, with
// status/counters exposed as byte registers on the fx bus.
// Optional feature macro: MEAS_AVG_MM_EN (forwarded to meas_mm_conv; averages
// millimetres instead of microseconds).
// Parameters:
//   AVG_LOG2   window depth is 2^AVG_LOG2 samples (1..5)
//   REG_BASE   fx-bus address of register 0
// Ports:
//   clk_sys, rst_n                         clock, async active-low reset
//   done_measure, err_measure, data_measure per-shot result strobe
//   avg_vld, avg_data                       averaged result and update strobe
//   fx_wr, fx_waddr, fx_data                fx write port (offset 4 = clear)
//   fx_rd, fx_raddr, fx_q                   fx read port, data one cycle later
module meas_avg
  import sg_pkg::*;
#(
  parameter int               AVG_LOG2 = 3,
  parameter logic [FX_AW-1:0] REG_BASE = 22'h000100
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             done_measure,
  input  logic             err_measure,
  input  logic [15:0]      data_measure,
  output logic             avg_vld,
  output logic [15:0]      avg_data,
  input  logic             fx_wr,
  input  logic [FX_AW-1:0] fx_waddr,
  input  logic [FX_DW-1:0] fx_data,
  input  logic             fx_rd,
  input  logic [FX_AW-1:0] fx_raddr,
  output logic [FX_DW-1:0] fx_q
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;
  localparam logic [FX_AW-1:0] CLR_ADDR = REG_BASE + FX_AW'(MA_REG_STAT);

  logic shot_ok, shot_err, clr, upd;

  logic        s1_vld;
  logic [15:0] s1_data;
  logic [15:0] last_raw;

  logic [15:0]         win_buf_q [DEPTH];
  logic [SW-1:0]       sum_q, sum_d, sum_new;
  logic [AVG_LOG2-1:0] wp_q, wp_d;
  logic                win_q, win_d;
  logic [15:0]         avg_q, avg_d;
  logic                avg_vld_q, avg_vld_d;

  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] samp_cnt_q, samp_cnt_d;
  ma_stat_t   stat_q, stat_d;

  logic [FX_AW-1:0] roff;
  logic             rd_hit;
  logic [7:0]       fx_q_q, fx_q_d;
  logic [7:0]       avg_sh_q, avg_sh_d;
  logic [7:0]       raw_sh_q, raw_sh_d;

  // Write data is irrelevant: any write to the status offset is a clear.
  logic unused_fx_data;
  assign unused_fx_data = ^fx_data;

  assign shot_ok  = done_measure & ~err_measure;
  assign shot_err = done_measure &  err_measure;
  assign clr      = fx_wr && (fx_waddr == CLR_ADDR);

  // A clear drops the sample already sitting in stage 1; the shot arriving
  // alongside the clear still enters stage 1 and prefills the emptied window.
  assign upd = s1_vld & ~clr;

  meas_mm_conv u_conv (
    .clk_i       (clk_sys),
    .rst_ni      (rst_n),
    .shot_vld_i  (shot_ok),
    .shot_data_i (data_measure),
    .vld_o       (s1_vld),
    .data_o      (s1_data),
    .raw_o       (last_raw)
  );

  // Stage 2: running sum over the ring buffer. An empty window is prefilled
  // with the first sample so the average is meaningful from the first shot.
  always_comb begin
    sum_new = sum_q - SW'(win_buf_q[wp_q]) + SW'(s1_data);
    if (!win_q) begin
      sum_new = {s1_data, {AVG_LOG2{1'b0}}};
    end

    sum_d     = sum_q;
    wp_d      = wp_q;
    win_d     = win_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;

    if (clr) begin
      win_d = 1'b0;
    end
    if (upd) begin
      sum_d     = sum_new;
      wp_d      = win_q ? (wp_q + AVG_LOG2'(1)) : AVG_LOG2'(1);
      win_d     = 1'b1;
      avg_d     = sum_new[SW-1:AVG_LOG2];
      avg_vld_d = 1'b1;
    end
  end

  // Buffer contents need no reset: the prefill overwrites every entry
  // before any of them is read into the sum.
  always_ff @(posedge clk_sys) begin
    if (upd) begin
      if (!win_q) begin
        for (int i = 0; i < DEPTH; i++) begin
          win_buf_q[i] <= s1_data;
        end
      end else begin
        win_buf_q[wp_q] <= s1_data;
      end
    end
  end

  // Counters and status track stage-1 acceptance, so they move at T+1.
  // A clear in the same cycle as a shot wins over an error but lets a valid
  // shot count as the first sample of the new window.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    samp_cnt_d = samp_cnt_q;
    stat_d     = stat_q;

    if (clr) begin
      err_cnt_d  = '0;
      samp_cnt_d = '0;
      stat_d     = '0;
    end

    if (shot_ok) begin
      if (clr) begin
        samp_cnt_d = 8'd1;
      end else if (samp_cnt_q != 8'hFF) begin
        samp_cnt_d = samp_cnt_q + 8'd1;
      end
      stat_d.win_vld  = 1'b1;
      stat_d.err_seen = 1'b0;
    end

    if (shot_err && !clr) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      stat_d.err_seen = 1'b1;
    end
  end

  // Read decode. Reading a low byte snapshots the matching high byte so a
  // two-read sequence always returns one coherent 16-bit value. fx_q is
  // forced to zero for idle and unmapped cycles so slaves can be OR-ed.
  assign roff   = fx_raddr - REG_BASE;
  assign rd_hit = fx_rd && (roff[FX_AW-1:3] == '0);

  always_comb begin
    fx_q_d   = '0;
    avg_sh_d = avg_sh_q;
    raw_sh_d = raw_sh_q;
    if (rd_hit) begin
      case (roff[2:0])
        MA_REG_AVG_L: begin
          fx_q_d   = avg_q[7:0];
          avg_sh_d = avg_q[15:8];
        end
        MA_REG_AVG_H: fx_q_d = avg_sh_q;
        MA_REG_RAW_L: begin
          fx_q_d   = last_raw[7:0];
          raw_sh_d = last_raw[15:8];
        end
        MA_REG_RAW_H: fx_q_d = raw_sh_q;
        MA_REG_STAT:  fx_q_d = {6'b0, stat_q};
        MA_REG_ERR:   fx_q_d = err_cnt_q;
        MA_REG_CNT:   fx_q_d = samp_cnt_q;
        default:      fx_q_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      wp_q       <= '0;
      win_q      <= 1'b0;
      avg_q      <= '0;
      avg_vld_q  <= 1'b0;
      err_cnt_q  <= '0;
      samp_cnt_q <= '0;
      stat_q     <= '0;
      fx_q_q     <= '0;
      avg_sh_q   <= '0;
      raw_sh_q   <= '0;
    end else begin
      sum_q      <= sum_d;
      wp_q       <= wp_d;
      win_q      <= win_d;
      avg_q      <= avg_d;
      avg_vld_q  <= avg_vld_d;
      err_cnt_q  <= err_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      stat_q     <= stat_d;
      fx_q_q     <= fx_q_d;
      avg_sh_q   <= avg_sh_d;
      raw_sh_q   <= raw_sh_d;
    end
  end

  assign avg_vld  = avg_vld_q;
  assign avg_data = avg_q;
  assign fx_q     = fx_q_q;

endmodule
